// File: rtl/mac_pkg.sv
// Shared definitions for the 8-lane dot-product MAC and its operand packer.
package mac_pkg;

    localparam int MAC_LANES  = 8;
    localparam int MAC_OPW    = 16;
    localparam int MAC_RESW   = 24;

    // Packer-side widths
    localparam int PACK_CNTW  = 16;
    localparam int PACK_LANEW = 4;
    localparam int PACK_IDXW  = (MAC_LANES > 1) ? $clog2(MAC_LANES) : 1;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } pack_state_t;

endpackage

// File: rtl/mac_operand_packer_if.sv
// Operand stream in, packed vector stream out, plus the hand-off counter.
interface mac_operand_packer_if;
    import mac_pkg::*;

    logic                           in_valid;
    logic                           in_ready;
    logic [MAC_OPW-1:0]             in_a;
    logic [MAC_OPW-1:0]             in_b;
    logic                           in_last;
    logic                           out_valid;
    logic                           out_ready;
    logic [MAC_LANES*MAC_OPW-1:0]   a_out;
    logic [MAC_LANES*MAC_OPW-1:0]   b_out;
    logic [PACK_LANEW-1:0]          out_lanes;
    logic [PACK_CNTW-1:0]           vec_count;

    // Source of operands and sink of packed vectors
    modport master (
        output in_valid, in_a, in_b, in_last, out_ready,
        input  in_ready, out_valid, a_out, b_out, out_lanes, vec_count
    );

    // The packer itself
    modport slave (
        input  in_valid, in_a, in_b, in_last, out_ready,
        output in_ready, out_valid, a_out, b_out, out_lanes, vec_count
    );

endinterface

// File: rtl/mac_operand_packer.sv
// Collects operand pairs one per accept into lane registers and presents the
// completed (or in_last-closed) vector to the MAC. Unwritten lanes stay zero.
module mac_operand_packer
    import mac_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    mac_operand_packer_if.slave  bus
);

    localparam int LANES = MAC_LANES;
    localparam int OPW   = MAC_OPW;
    localparam int CNTW  = PACK_CNTW;
    localparam int LANEW = PACK_LANEW;
    localparam int IDXW  = PACK_IDXW;

    pack_state_t         state_reg, state_next;
    logic [IDXW-1:0]     idx_reg, idx_next;
    logic [LANEW-1:0]    out_lanes_reg, out_lanes_next;
    logic [CNTW-1:0]     vec_count_reg;

    logic                accept;
    logic                handoff;
    logic                closing;

    // In HOLD the packer can only take a new pair if the held vector leaves
    // in the same cycle; lane 0 is free by then.
    assign bus.in_ready = (state_reg == FILL) ? 1'b1 : bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;
    assign handoff      = (state_reg == HOLD) && bus.out_ready;
    assign closing      = (idx_reg == IDXW'(LANES - 1)) || bus.in_last;

    assign bus.out_valid = (state_reg == HOLD);
    assign bus.out_lanes = out_lanes_reg;
    assign bus.vec_count = vec_count_reg;

    // State, lane index and populated-lane count registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= FILL;
            idx_reg       <= '0;
            out_lanes_reg <= '0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            out_lanes_reg <= out_lanes_next;
        end
    end

    // Next-state logic for fill/hold sequencing
    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        out_lanes_next = out_lanes_reg;
        case (state_reg)
            FILL: begin
                if (accept) begin
                    if (closing) begin
                        state_next     = HOLD;
                        out_lanes_next = LANEW'(idx_reg) + LANEW'(1);
                        idx_next       = '0;
                    end else begin
                        idx_next       = idx_reg + IDXW'(1);
                    end
                end
            end
            HOLD: begin
                if (handoff) begin
                    if (accept) begin
                        // New pair lands in lane 0 of the next vector
                        idx_next = (LANES > 1) ? IDXW'(1) : '0;
                        if (bus.in_last || (LANES == 1)) begin
                            state_next     = HOLD;
                            out_lanes_next = LANEW'(1);
                            idx_next       = '0;
                        end else begin
                            state_next     = FILL;
                            out_lanes_next = '0;
                        end
                    end else begin
                        state_next     = FILL;
                        idx_next       = '0;
                        out_lanes_next = '0;
                    end
                end
            end
            default: begin
                state_next     = FILL;
                idx_next       = '0;
                out_lanes_next = '0;
            end
        endcase
    end

    // Hand-off counter, wraps naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_count_reg <= '0;
        end else if (handoff) begin
            vec_count_reg <= vec_count_reg + CNTW'(1);
        end
    end

    // One register pair per lane; a hand-off clears every lane except the one
    // being written by a simultaneous accept.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [OPW-1:0] a_lane_reg;
            logic [OPW-1:0] b_lane_reg;
            logic           wr_en;

            assign wr_en = accept && (handoff ? (gi == 0) : (idx_reg == IDXW'(gi)));

            // Lane storage
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_lane_reg <= '0;
                    b_lane_reg <= '0;
                end else if (wr_en) begin
                    a_lane_reg <= bus.in_a;
                    b_lane_reg <= bus.in_b;
                end else if (handoff) begin
                    a_lane_reg <= '0;
                    b_lane_reg <= '0;
                end
            end

            assign bus.a_out[gi*OPW +: OPW] = a_lane_reg;
            assign bus.b_out[gi*OPW +: OPW] = b_lane_reg;
        end
    endgenerate

endmodule

// File: tb/tb_mac_operand_packer.sv
// Directed bench for mac_operand_packer with a queue-based reference model.
module tb_mac_operand_packer;
    import mac_pkg::*;

    typedef struct {
        logic [127:0] a;
        logic [127:0] b;
        logic [3:0]   lanes;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   passed = 0;

    mac_operand_packer_if bus ();

    mac_operand_packer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference dot product, truncated to the MAC result width
    function automatic logic [23:0] mac(input logic [127:0] a, input logic [127:0] b);
        logic [23:0] sum;
        logic [31:0] p;
        sum = '0;
        for (int i = 0; i < MAC_LANES; i++) begin
            p   = a[i*16 +: 16] * b[i*16 +: 16];
            sum = sum + p[23:0];
        end
        return sum;
    endfunction

    // ---------------- reference model ----------------
    vec_t          expq[$];
    logic [15:0]   pa[$];
    logic [15:0]   pb[$];
    logic [15:0]   m_count = '0;

    always @(negedge clk) begin
        logic exp_valid, exp_ready;
        vec_t v;
        if (rst) begin
            expq.delete();
            pa.delete();
            pb.delete();
            m_count = '0;
        end else begin
            exp_valid = (expq.size() != 0);
            exp_ready = exp_valid ? bus.out_ready : 1'b1;
            check("out_valid", 128'(bus.out_valid), 128'(exp_valid));
            check("in_ready", 128'(bus.in_ready), 128'(exp_ready));
            check("vec_count", 128'(bus.vec_count), 128'(m_count));
            if (exp_valid) begin
                check("a_out", bus.a_out, expq[0].a);
                check("b_out", bus.b_out, expq[0].b);
                check("out_lanes", 128'(bus.out_lanes), 128'(expq[0].lanes));
            end
            if (exp_valid && bus.out_ready) begin
                void'(expq.pop_front());
                m_count = m_count + 16'd1;
            end
            if (bus.in_valid && exp_ready) begin
                pa.push_back(bus.in_a);
                pb.push_back(bus.in_b);
                if (pa.size() == MAC_LANES || bus.in_last) begin
                    v.a = '0;
                    v.b = '0;
                    for (int i = 0; i < pa.size(); i++) begin
                        v.a[i*16 +: 16] = pa[i];
                        v.b[i*16 +: 16] = pb[i];
                    end
                    v.lanes = 4'(pa.size());
                    expq.push_back(v);
                    pa.delete();
                    pb.delete();
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic last,
                        output int cycles);
        logic acc;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_last  = last;
        cycles = 0;
        acc    = 1'b0;
        while (!acc && cycles < 50) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            cycles++;
        end
        check("accept_within_bound", 128'(acc), 128'(1));
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        logic [127:0] snap_a;

        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("rst_out_valid", 128'(bus.out_valid), 128'(0));
        check("rst_a_out", bus.a_out, 128'(0));
        check("rst_b_out", bus.b_out, 128'(0));
        check("rst_out_lanes", 128'(bus.out_lanes), 128'(0));
        check("rst_vec_count", 128'(bus.vec_count), 128'(0));
        check("rst_in_ready", 128'(bus.in_ready), 128'(1));
        @(posedge clk);
        #1;

        // Full vector of 8 back-to-back pairs
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) send(16'(i + 1), 16'd2, 1'b0, cyc);
        check("full_out_valid", 128'(bus.out_valid), 128'(1));
        check("full_a_out", bus.a_out, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
        check("full_out_lanes", 128'(bus.out_lanes), 128'(8));
        check("full_mac", 128'(mac(bus.a_out, bus.b_out)), 128'(72));
        @(posedge clk);
        #1;
        check("full_vec_count", 128'(bus.vec_count), 128'(1));

        // Three-pair vector closed by in_last, held with out_ready low
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(16'hFFFF, 16'hFFFF, (i == 2), cyc);
        check("short_out_lanes", 128'(bus.out_lanes), 128'(3));
        check("short_upper_zero", 128'(bus.a_out[127:48]), 128'(0));
        check("short_mac", 128'(mac(bus.a_out, bus.b_out)), 128'(24'hFA0003));
        snap_a = bus.a_out;

        // Pair waiting while the held vector is stalled
        bus.in_valid = 1'b1;
        bus.in_a     = 16'h0005;
        bus.in_b     = 16'h0006;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_in_ready", 128'(bus.in_ready), 128'(0));
            check("stall_a_stable", bus.a_out, snap_a);
            check("stall_vec_count", 128'(bus.vec_count), 128'(1));
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        send(16'h0005, 16'h0006, 1'b0, cyc);
        check("release_vec_count", 128'(bus.vec_count), 128'(2));
        check("release_lane0", bus.a_out, 128'h0005);
        check("release_out_valid", 128'(bus.out_valid), 128'(0));
        @(posedge clk);
        #1;
        check("single_handoff", 128'(bus.vec_count), 128'(2));

        // Complete that vector, then stream a second one with no gap
        for (int i = 0; i < 7; i++) send(16'(16'h0101 + i), 16'(16'h0010 + i), 1'b0, cyc);
        send(16'h0200, 16'h0001, 1'b0, cyc);
        check("stream_no_bubble_first", 128'(cyc), 128'(1));
        check("stream_lane0_a", bus.a_out, 128'h0200);
        check("stream_lane0_b", bus.b_out, 128'h0001);
        for (int i = 1; i < 8; i++) begin
            send(16'(16'h0200 + i), 16'h0001, 1'b0, cyc);
            check("stream_no_bubble", 128'(cyc), 128'(1));
        end
        @(posedge clk);
        #1;
        check("stream_vec_count", 128'(bus.vec_count), 128'(4));

        // Asynchronous reset mid-fill
        for (int i = 0; i < 5; i++) send(16'(16'h0300 + i), 16'(16'h0300 + i), 1'b0, cyc);
        #2 rst = 1'b1;
        #1;
        check("arst_out_valid", 128'(bus.out_valid), 128'(0));
        check("arst_a_out", bus.a_out, 128'(0));
        check("arst_b_out", bus.b_out, 128'(0));
        check("arst_out_lanes", 128'(bus.out_lanes), 128'(0));
        check("arst_vec_count", 128'(bus.vec_count), 128'(0));
        check("arst_in_ready", 128'(bus.in_ready), 128'(1));
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 8; i++) send(16'(16'h0040 + i), 16'(i + 1), 1'b0, cyc);
        check("clean_a_out", bus.a_out, 128'h0047_0046_0045_0044_0043_0042_0041_0040);
        check("clean_out_lanes", 128'(bus.out_lanes), 128'(8));
        @(posedge clk);
        #1;
        check("clean_vec_count", 128'(bus.vec_count), 128'(1));

        // Counter wrap over 65536 single-pair vectors
        rst = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 65536; k++) send(16'(k), ~16'(k), 1'b1, cyc);
        @(posedge clk);
        #1;
        check("wrap_vec_count", 128'(bus.vec_count), 128'(0));
        check("wrap_out_valid", 128'(bus.out_valid), 128'(0));
        @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mac_operand_packer.md
# mac_operand_packer

Sequential front-end for the 8-lane, 16-bit dot-product MAC (packed 128-bit `a_in`/`b_in`, 24-bit result). It accepts operand pairs one at a time over a valid/ready stream, packs them into lane order, and presents complete packed vectors to the MAC with a valid/ready handshake. Partial vectors can be closed early with `in_last`; unused lanes are zero-filled so they contribute nothing to the sum. It is the writer for the MAC's packed-operand reader side and sits between the operand stream source and the MAC.

## Interface
- `LANES`, 8, operand pairs per packed vector. Must match the MAC lane count.
- `OPW`, 16, operand width in bits.
- `CNTW`, 16, width of the handed-off-vector counter.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  operand pair present.
- `in_ready`  out  1  packer accepts the pair this cycle.
- `in_a`  in  OPW  A operand.
- `in_b`  in  OPW  B operand.
- `in_last`  in  1  closes the current vector after this pair.
- `out_valid`  out  1  packed vector available.
- `out_ready`  in  1  MAC side takes the vector.
- `a_out`  out  LANES*OPW  packed A; lane i at bits [i*OPW +: OPW].
- `b_out`  out  LANES*OPW  packed B, same lane layout.
- `out_lanes`  out  4  number of populated lanes, 1..8, valid with `out_valid`.
- `vec_count`  out  CNTW  vectors handed off since reset; wraps modulo 2^CNTW.

## Operation
- Accept = `in_valid && in_ready`. Hand-off = `out_valid && out_ready`.
- States: FILL (collecting; `out_valid`=0) and HOLD (vector complete; `out_valid`=1).
- FILL:
  - `in_ready`=1.
  - An accept writes `in_a`/`in_b` into lane `idx`, then increments `idx`.
  - If `idx`==LANES-1 or `in_last`=1 on that accept: `out_lanes` = `idx`+1, go to HOLD.
- HOLD:
  - `in_ready` = `out_ready`.
  - `a_out`, `b_out` and `out_lanes` hold stable until hand-off.
  - On hand-off: increment `vec_count`, clear all lanes to zero, set `idx`=0.
  - If an accept occurs in the same cycle as the hand-off, the pair is written to lane 0 and `idx`=1. If `in_last`=1 or LANES=1, stay in HOLD with `out_lanes`=1. Otherwise go to FILL.
  - Hand-off without an accept: go to FILL with `idx`=0.
- Lanes at or above `out_lanes` always read zero. A vector is never empty, because `in_last` always comes with a pair.
- `in_last` together with `in_valid`=0 is ignored.
- No arithmetic beyond the `idx` counter (0..LANES-1) and `vec_count` (wrapping). Operands pass through unmodified.

## Timing
- Reset values: `out_valid`=0, `a_out`=0, `b_out`=0, `out_lanes`=0, `vec_count`=0, `in_ready`=1 (combinational from state), state FILL, `idx`=0.
- Latency: `out_valid` rises the cycle after the closing accept.
- Throughput: with `out_ready` held high, one pair per cycle sustained, with no bubble between vectors.
- `out_valid`, once high, stays high until hand-off, and the data must not change meanwhile.
- `in_ready` depends combinationally on `out_ready` only in HOLD. There is no path from `in_valid` to `in_ready`.
- Reset asserted mid-fill or in HOLD discards the partial or held vector immediately. No hand-off is counted.

## Structure
- Shared package `mac_pkg`:
  - `MAC_LANES`=8, `MAC_OPW`=16, `MAC_RESW`=24.
  - State enum `pack_state_t` {FILL, HOLD}.
  - The MAC and this packer both take lane count and widths from the package.
- Single module. The lane register array is a generate loop with a per-lane write enable, so no sub-module is needed.

## Test plan
- Reset, then 8 back-to-back pairs (a=i+1, b=2, i=0..7) with `out_ready`=1:
  - `out_valid` one cycle after the 8th accept.
  - `a_out`=0x0008_0007_..._0001, `out_lanes`=8.
  - Feeding the MAC gives result 72.
  - `vec_count`=1.
- 3 pairs (a=0xFFFF, b=0xFFFF) with `in_last` on the third:
  - `out_lanes`=3, bits [127:48] zero.
  - MAC result = 3*0xFFFE0001 truncated to 24 bits = 0xFA0003.
- Hold `out_ready`=0 for 5 cycles while in HOLD:
  - `in_ready`=0, outputs stable, `vec_count` unchanged.
  - Raising `out_ready` gives exactly one hand-off.
- Two vectors streamed continuously with `out_ready`=1:
  - The first pair of vector 2 is accepted in the hand-off cycle of vector 1 and lands in lane 0.
  - Other lanes of vector 2 are zero until written; no bubble.
- Assert `rst` asynchronously after 5 accepts:
  - All outputs return to reset values immediately.
  - The next 8 pairs form a clean vector with no stale lanes.
- 65536 single-pair `in_last` vectors: `vec_count` wraps to 0.
